// File: rtl/div_pipe_16by8_if.sv
// div_pipe_16by8_if
//   Operand/result bundle for the pipelined divider. The clock and reset are
//   not part of the bundle; they stay plain ports on the divider.
//
//   Signals (size = divisor width):
//     div_en_in  1       operand valid
//     div_a      2*size  dividend
//     div_b      size    divisor
//     div_en_out 1       result valid, one-cycle pulse per operation
//     div_q      2*size  quotient
//     div_r      size    remainder
//     div_dz     1       divide-by-zero flag, qualified by div_en_out
//
//   Modports:
//     master  issues operands, observes results (testbench / upstream logic)
//     slave   the divider itself
interface div_pipe_16by8_if #(
  parameter int size = 8
);

  logic                div_en_in;
  logic [2*size-1:0]   div_a;
  logic [size-1:0]     div_b;
  logic                div_en_out;
  logic [2*size-1:0]   div_q;
  logic [size-1:0]     div_r;
  logic                div_dz;

  modport master (
    output div_en_in, div_a, div_b,
    input  div_en_out, div_q, div_r, div_dz
  );

  modport slave (
    input  div_en_in, div_a, div_b,
    output div_en_out, div_q, div_r, div_dz
  );

endinterface

// File: rtl/div_pipe_16by8.sv
// div_pipe_16by8
//   Fully pipelined restoring divider: 2*size-bit dividend by size-bit
//   divisor, giving a 2*size-bit quotient and a size-bit remainder. One
//   operation is accepted per clock, with no backpressure. Results appear
//   size+2 register levels after the operands (10 clocks for size = 8).
//
//   Pipeline:
//     stage 0       input register (operand conditioning)
//     stages 1..size  two restoring quotient bits each, MSB first
//     output reg    result formatting, qualified by div_en_out
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous reset, active-high
//     bus   div_pipe_16by8_if.slave (operands in, results out)
//
//   Build option:
//     DIV_SIGNED_EN  when defined, operands are two's complement. Magnitudes
//                    are divided by the unsigned core; the quotient truncates
//                    toward zero and the remainder follows the dividend's
//                    sign. Divide-by-zero still returns the raw-bit result.
module div_pipe_16by8 #(
  parameter int size = 8
) (
  input  logic               clk,
  input  logic               rst,
  div_pipe_16by8_if.slave    bus
);

  localparam int DW = 2 * size;

  // One restoring step: shift the next dividend bit into the partial
  // remainder (size+1 bits wide) and subtract the divisor when it fits.
  // Returns {quotient_bit, new_remainder}.
  function automatic logic [size:0] div_step(
    input logic [size-1:0] rem,
    input logic            din,
    input logic [size-1:0] dvs
  );
    logic [size:0] sh;
    logic [size:0] dv;
    sh = {rem, din};
    dv = {1'b0, dvs};
    if (sh >= dv) begin
      sh = sh - dv;
      return {1'b1, sh[size-1:0]};
    end else begin
      return {1'b0, sh[size-1:0]};
    end
  endfunction

  // One pipeline stage = two restoring steps. The dividend and the quotient
  // share one shift register: dividend bits leave at the top while quotient
  // bits enter at the bottom, so after 2*size steps it holds the quotient.
  // Returns {shift_register, remainder}.
  function automatic logic [DW+size-1:0] stage_calc(
    input logic [DW-1:0]   dq,
    input logic [size-1:0] rem,
    input logic [size-1:0] dvs
  );
    logic [size:0]   s1;
    logic [size:0]   s2;
    logic [DW-1:0]   dq1;
    logic [DW-1:0]   dq2;
    s1  = div_step(rem, dq[DW-1], dvs);
    dq1 = {dq[DW-2:0], s1[size]};
    s2  = div_step(s1[size-1:0], dq1[DW-1], dvs);
    dq2 = {dq1[DW-2:0], s2[size]};
    return {dq2, s2[size-1:0]};
  endfunction

  // Pipeline state, index = stage number
  logic [DW-1:0]   dq_r    [0:size];
  logic [size-1:0] rem_r   [0:size];
  logic [size-1:0] dvs_r   [0:size-1];   // the last stage no longer needs it
  logic            vld_r   [0:size];
  logic            dz_r    [0:size];
`ifdef DIV_SIGNED_EN
  logic            neg_q_r [0:size];
  logic            neg_r_r [0:size];
`endif

  // Next-stage values
  logic [DW-1:0]   dq_s    [1:size];
  logic [size-1:0] rem_s   [1:size];

  // Conditioned operands for stage 0
  logic [DW-1:0]   a_in_s;
  logic [size-1:0] b_in_s;
  logic            dz_in_s;
`ifdef DIV_SIGNED_EN
  logic            neg_q_in_s;
  logic            neg_r_in_s;
`endif

  // Result formatting ahead of the output register
  logic [DW-1:0]   q_out_s;
  logic [size-1:0] r_out_s;

  // Output register
  logic            en_out_r;
  logic [DW-1:0]   q_out_r;
  logic [size-1:0] r_out_r;
  logic            dz_out_r;

  // Operand conditioning: flag zero divisor, take magnitudes in signed mode
  always_comb begin
    dz_in_s = (bus.div_b == {size{1'b0}});
    a_in_s  = bus.div_a;
    b_in_s  = bus.div_b;
`ifdef DIV_SIGNED_EN
    neg_q_in_s = 1'b0;
    neg_r_in_s = 1'b0;
    // A zero divisor keeps the raw dividend so the remainder reports raw bits.
    if (!dz_in_s) begin
      a_in_s     = bus.div_a[DW-1]   ? (-bus.div_a) : bus.div_a;
      b_in_s     = bus.div_b[size-1] ? (-bus.div_b) : bus.div_b;
      neg_q_in_s = bus.div_a[DW-1] ^ bus.div_b[size-1];
      neg_r_in_s = bus.div_a[DW-1];
    end else begin
      a_in_s = bus.div_a;
      b_in_s = bus.div_b;
    end
`endif
  end

  // Divider stages: two quotient bits per stage
  always_comb begin
    for (int k = 1; k <= size; k++) begin
      {dq_s[k], rem_s[k]} = stage_calc(dq_r[k-1], rem_r[k-1], dvs_r[k-1]);
    end
  end

  // Pipeline registers; idle slots carry zeros so bubbles stay quiet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= size; k++) begin
        dq_r[k]    <= {DW{1'b0}};
        rem_r[k]   <= {size{1'b0}};
        vld_r[k]   <= 1'b0;
        dz_r[k]    <= 1'b0;
`ifdef DIV_SIGNED_EN
        neg_q_r[k] <= 1'b0;
        neg_r_r[k] <= 1'b0;
`endif
      end
      for (int k = 0; k < size; k++) begin
        dvs_r[k] <= {size{1'b0}};
      end
    end else begin
      vld_r[0] <= bus.div_en_in;
      if (bus.div_en_in) begin
        dq_r[0]    <= a_in_s;
        rem_r[0]   <= {size{1'b0}};
        dvs_r[0]   <= b_in_s;
        dz_r[0]    <= dz_in_s;
`ifdef DIV_SIGNED_EN
        neg_q_r[0] <= neg_q_in_s;
        neg_r_r[0] <= neg_r_in_s;
`endif
      end else begin
        dq_r[0]    <= {DW{1'b0}};
        rem_r[0]   <= {size{1'b0}};
        dvs_r[0]   <= {size{1'b0}};
        dz_r[0]    <= 1'b0;
`ifdef DIV_SIGNED_EN
        neg_q_r[0] <= 1'b0;
        neg_r_r[0] <= 1'b0;
`endif
      end

      for (int k = 1; k <= size; k++) begin
        vld_r[k] <= vld_r[k-1];
        if (vld_r[k-1]) begin
          dq_r[k]    <= dq_s[k];
          rem_r[k]   <= rem_s[k];
          dz_r[k]    <= dz_r[k-1];
`ifdef DIV_SIGNED_EN
          neg_q_r[k] <= neg_q_r[k-1];
          neg_r_r[k] <= neg_r_r[k-1];
`endif
        end else begin
          dq_r[k]    <= {DW{1'b0}};
          rem_r[k]   <= {size{1'b0}};
          dz_r[k]    <= 1'b0;
`ifdef DIV_SIGNED_EN
          neg_q_r[k] <= 1'b0;
          neg_r_r[k] <= 1'b0;
`endif
        end
      end

      for (int k = 1; k < size; k++) begin
        if (vld_r[k-1]) begin
          dvs_r[k] <= dvs_r[k-1];
        end else begin
          dvs_r[k] <= {size{1'b0}};
        end
      end
    end
  end

  // Result formatting: divide-by-zero pattern, or sign restoration
  always_comb begin
    q_out_s = dq_r[size];
    r_out_s = rem_r[size];
    if (dz_r[size]) begin
      // The remainder register already holds the low dividend bits here:
      // with a zero divisor every step "fits" and nothing is subtracted.
      q_out_s = {DW{1'b1}};
      r_out_s = rem_r[size];
    end else begin
`ifdef DIV_SIGNED_EN
      // The most-negative / -1 case wraps naturally: magnitude 2^(DW-1)
      // with a positive sign is the same bit pattern.
      q_out_s = neg_q_r[size] ? (-dq_r[size])  : dq_r[size];
      r_out_s = neg_r_r[size] ? (-rem_r[size]) : rem_r[size];
`else
      q_out_s = dq_r[size];
      r_out_s = rem_r[size];
`endif
    end
  end

  // Output register: results only in the cycle they are valid, else zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_out_r <= 1'b0;
      q_out_r  <= {DW{1'b0}};
      r_out_r  <= {size{1'b0}};
      dz_out_r <= 1'b0;
    end else if (vld_r[size]) begin
      en_out_r <= 1'b1;
      q_out_r  <= q_out_s;
      r_out_r  <= r_out_s;
      dz_out_r <= dz_r[size];
    end else begin
      en_out_r <= 1'b0;
      q_out_r  <= {DW{1'b0}};
      r_out_r  <= {size{1'b0}};
      dz_out_r <= 1'b0;
    end
  end

  assign bus.div_en_out = en_out_r;
  assign bus.div_q      = q_out_r;
  assign bus.div_r      = r_out_r;
  assign bus.div_dz     = dz_out_r;

endmodule

// File: tb/tb_div_pipe_16by8.sv
// tb_div_pipe_16by8
//   Directed-vector bench for div_pipe_16by8 (size = 8). A reference model
//   computes quotient/remainder with plain integer arithmetic; every issued
//   operation is queued with the cycle its result is due, and a single
//   compare process checks all outputs on every falling edge (valid result
//   when due, all zeros otherwise). Hand-computed values pin the model.
module tb_div_pipe_16by8;

  localparam int SIZE = 8;
  localparam int LAT  = SIZE + 2;

  typedef struct {
    int          due;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edges = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  div_pipe_16by8_if #(.size(SIZE)) bus ();

  div_pipe_16by8 #(.size(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  // Reference: returns {dz, q[15:0], r[7:0]}
  function automatic logic [24:0] model(input logic [15:0] a, input logic [7:0] b);
    logic [15:0] qq;
    logic [7:0]  rr;
    int          sa;
    int          sb;
    if (b == 8'd0) begin
      return {1'b1, 16'hFFFF, a[7:0]};
    end
`ifdef DIV_SIGNED_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
    qq = 16'(sa / sb);
    rr = 8'(sa % sb);
`else
    sa = int'(a);
    sb = int'(b);
    qq = 16'(sa / sb);
    rr = 8'(sa % sb);
`endif
    return {1'b0, qq, rr};
  endfunction

  task automatic pin(input string name, input logic [15:0] a, input logic [7:0] b,
                     input logic [15:0] eq, input logic [7:0] er, input logic edz);
    logic [24:0] got;
    got = model(a, b);
    n_checks++;
    if (got !== {edz, eq, er}) begin
      n_fail++;
      $display("FAIL model_%s: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
               name, got[23:8], got[7:0], got[24], eq, er, edz);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [7:0] b);
    logic [24:0] m;
    exp_t        e;
    @(negedge clk);
    bus.div_en_in = 1'b1;
    bus.div_a     = a;
    bus.div_b     = b;
    m    = model(a, b);
    e.due = edges + LAT;
    e.q   = m[23:8];
    e.r   = m[7:0];
    e.dz  = m[24];
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.div_en_in = 1'b0;
      bus.div_a     = 16'h0000;
      bus.div_b     = 8'h00;
    end
  endtask

  // Compare process: every falling edge, outputs must equal the model
  always @(negedge clk) begin
    logic        ee;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        edz;
    ee = 1'b0; eq = 16'h0000; er = 8'h00; edz = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == edges) begin
      ee  = 1'b1;
      eq  = exp_q[0].q;
      er  = exp_q[0].r;
      edz = exp_q[0].dz;
      void'(exp_q.pop_front());
    end
    n_checks++;
    if (bus.div_en_out !== ee || bus.div_q !== eq || bus.div_r !== er || bus.div_dz !== edz) begin
      n_fail++;
      $display("FAIL out_edge%0d: got en=%b q=%h r=%h dz=%b, expected en=%b q=%h r=%h dz=%b",
               edges, bus.div_en_out, bus.div_q, bus.div_r, bus.div_dz, ee, eq, er, edz);
    end
  end

  initial begin
    bus.div_en_in = 1'b0;
    bus.div_a     = 16'h0000;
    bus.div_b     = 8'h00;

    // Model pins
`ifdef DIV_SIGNED_EN
    pin("neg_by_pos", 16'hFF9C, 8'h07, 16'hFFF2, 8'hFE, 1'b0);
    pin("pos_by_neg", 16'h0064, 8'hF9, 16'hFFF2, 8'h02, 1'b0);
    pin("overflow",   16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0);
    pin("dz_raw",     16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1);
    pin("81_9",       16'd81,   8'd9,  16'd9,    8'd0,  1'b0);
`else
    pin("1000_7",     16'd1000, 8'd7,  16'd142,  8'd6,  1'b0);
    pin("ffff_ff",    16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0);
    pin("ffff_1",     16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0);
    pin("fe_ff",      16'h00FE, 8'hFF, 16'h0000, 8'hFE, 1'b0);
    pin("100_3",      16'd100,  8'd3,  16'd33,   8'd1,  1'b0);
    pin("200_9",      16'd200,  8'd9,  16'd22,   8'd2,  1'b0);
    pin("255_16",     16'd255,  8'd16, 16'd15,   8'd15, 1'b0);
    pin("dz",         16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1);
    pin("50_5",       16'd50,   8'd5,  16'd10,   8'd0,  1'b0);
    pin("81_9",       16'd81,   8'd9,  16'd9,    8'd0,  1'b0);
`endif

    // Reset state observed for a few cycles, then release
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Basic single operation
    issue(16'd1000, 8'd7);
    idle(12);

    // Extremes, back to back
    issue(16'hFFFF, 8'hFF);
    issue(16'hFFFF, 8'h01);
    issue(16'h00FE, 8'hFF);
    idle(1);

    // Back-to-back then a one-cycle gap
    issue(16'd100, 8'd3);
    issue(16'd200, 8'd9);
    issue(16'd255, 8'd16);
    idle(1);
    issue(16'd7, 8'd2);
    idle(12);

    // Divide by zero followed by a normal operation
    issue(16'h1234, 8'h00);
    issue(16'd50, 8'd5);
    idle(12);

    // Signed-interpretation vectors (plain unsigned results by default)
    issue(16'hFF9C, 8'h07);
    issue(16'h0064, 8'hF9);
    issue(16'h8000, 8'hFF);
    idle(12);

    // Reset mid-flight: four operations discarded
    issue(16'd10, 8'd3);
    issue(16'd20, 8'd3);
    issue(16'd30, 8'd3);
    issue(16'd40, 8'd3);
    idle(2);
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    issue(16'd81, 8'd9);
    idle(14);

    // Every queued result must have been seen
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
